// File: rtl/prog_stim_seq.sv
// prog_stim_seq: loadable program table driving a core by pc, with run control and a store log.
// Latency: pc -> inst is one cycle; store -> log_valid is one cycle (first-word-fall-through).
// Backpressure: none toward the core; stores arriving on a full log are dropped and flagged in log_ovf.
// Ports: clk/rst (sync, active-high); ld_en/ld_addr/ld_data program write (IDLE only);
//   start run request; pc -> inst instruction path; proc_nrst core reset; wr_en/addr/wdata/wmask
//   store capture; log_pop/log_valid/log_addr/log_data/log_mask/log_ovf store log;
//   busy/done/timeout/cycles run status.

// stim_fifo: generic first-word-fall-through FIFO with synchronous clear.
// Latency: a push is visible at head_dat on the next cycle.
// Backpressure: push is refused when full unless a pop occurs in the same cycle.
module stim_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_dat
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW:0]   r_cnt;
  logic          w_pop;
  logic          w_push;

  assign full     = (r_cnt == (PW+1)'(DEPTH));
  assign empty    = (r_cnt == '0);
  assign head_dat = r_mem[r_rp];
  assign w_pop    = pop_rdy && !empty;
  // A pop frees the head slot in the same edge, so a full FIFO can still accept.
  assign w_push   = push_vld && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= push_dat;
  end
endmodule

module prog_stim_seq #(
  parameter int          XLEN       = 64,
  parameter int          DEPTH      = 16,
  parameter logic [31:0] BASE_PC    = 32'h0000_0000,
  parameter logic [31:0] HALT_PC    = 32'h0000_0040,
  parameter int          LOG_DEPTH  = 4,
  parameter int          MAX_CYCLES = 256,
  parameter logic [31:0] NOP        = 32'h0000_0013,
  localparam int         AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              start,
  input  logic [31:0]       pc,
  output logic [31:0]       inst,
  output logic              proc_nrst,
  input  logic              wr_en,
  input  logic [31:0]       addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN/8-1:0] wmask,
  input  logic              log_pop,
  output logic              log_valid,
  output logic [31:0]       log_addr,
  output logic [XLEN-1:0]   log_data,
  output logic [XLEN/8-1:0] log_mask,
  output logic              log_ovf,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       cycles
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [31:0]       addr;
    logic [XLEN-1:0]   data;
    logic [XLEN/8-1:0] mask;
  } log_ent_t;

  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_prog [DEPTH];
  logic [31:0] r_inst;
  logic [31:0] r_cycles;
  logic        r_timeout;
  logic        r_ovf;

  logic        w_start;
  logic        w_halt;
  logic        w_budget_end;
  logic [31:0] w_off;
  logic        w_in_range;
  logic [31:0] w_fetch;
  logic        w_push;
  logic        w_full;
  logic        w_empty;
  log_ent_t    w_head;
  log_ent_t    w_push_ent;

  assign w_start      = start && (r_state != S_RUN);
  assign w_halt       = (r_state == S_RUN) && (pc == HALT_PC);
  assign w_budget_end = (r_state == S_RUN) && (r_cycles == 32'(MAX_CYCLES - 1));

  // Offset comparison covers the upper bound; the lower bound is checked on pc directly
  // so that a pc below BASE_PC cannot wrap into range.
  assign w_off      = pc - BASE_PC;
  assign w_in_range = (pc[1:0] == 2'b00) && (pc >= BASE_PC) && (w_off < SPAN);
  assign w_fetch    = w_in_range ? r_prog[w_off[AW+1:2]] : NOP;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_halt || w_budget_end) w_state_nxt = S_DONE;
      S_DONE:  if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Program table is deliberately outside reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (ld_en && (r_state == S_IDLE)) r_prog[ld_addr] <= ld_data;
  end

  // The instruction register drops to NOP on the edge that leaves RUN so DONE never
  // shows a stale fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst    <= NOP;
      r_cycles  <= '0;
      r_timeout <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_inst <= ((r_state == S_RUN) && (w_state_nxt == S_RUN)) ? w_fetch : NOP;
      if (w_start) begin
        r_cycles  <= '0;
        r_timeout <= 1'b0;
        r_ovf     <= 1'b0;
      end else if (r_state == S_RUN) begin
        if (r_cycles != '1) r_cycles <= r_cycles + 32'd1;
        if (w_budget_end && !w_halt) r_timeout <= 1'b1;
        if (w_push && w_full && !log_pop) r_ovf <= 1'b1;
      end
    end
  end

  assign w_push     = wr_en && (r_state == S_RUN);
  assign w_push_ent = '{addr: addr, data: wdata, mask: wmask};

  stim_fifo #(
    .W     ($bits(log_ent_t)),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_start),
    .push_vld (w_push),
    .push_dat (w_push_ent),
    .pop_rdy  (log_pop),
    .full     (w_full),
    .empty    (w_empty),
    .head_dat (w_head)
  );

  assign inst      = r_inst;
  assign proc_nrst = (r_state == S_RUN);
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign timeout   = r_timeout;
  assign cycles    = r_cycles;
  assign log_ovf   = r_ovf;
  assign log_valid = !w_empty;
  assign log_addr  = w_head.addr;
  assign log_data  = w_head.data;
  assign log_mask  = w_head.mask;
endmodule

// File: doc/prog_stim_seq.md
Name: prog_stim_seq

Overview:
Synthesizable, parametrised stimulus sequencer for the RISC-V `processor` core. It replaces hand-timed instruction driving with a loadable program table indexed by the core's pc. It holds the core in reset outside a run and terminates a run on a halt address or a cycle timeout. Store transactions issued by the core during a run are captured into a readable log FIFO for checking.

Parameters:
XLEN, 64, store data width (wdata/log_data); XLEN/8 mask bits
DEPTH, 16, program words (power of 2); AW = log2(DEPTH)
BASE_PC, 32'h0000_0000, byte address of program word 0
HALT_PC, 32'h0000_0040, pc value that ends a run
LOG_DEPTH, 4, store-log FIFO entries (power of 2)
MAX_CYCLES, 256, RUN-cycle budget before timeout (>=2)
NOP, 32'h0000_0013, instruction driven when no program word applies (addi x0,x0,0)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
ld_en  in  1  program write strobe, honoured only in IDLE
ld_addr  in  AW  program word index
ld_data  in  32  program word
start  in  1  begin run, honoured in IDLE or DONE
pc  in  32  core program counter
inst  out  32  instruction to core, registered
proc_nrst  out  1  core reset, active-low; 1 only in RUN
wr_en  in  1  core store strobe
addr  in  32  core store address
wdata  in  XLEN  core store data
wmask  in  XLEN/8  core store byte mask
log_pop  in  1  consume head log entry
log_valid  out  1  log non-empty
log_addr  out  32  head entry address
log_data  out  XLEN  head entry data
log_mask  out  XLEN/8  head entry mask
log_ovf  out  1  sticky: store dropped on full log
busy  out  1  state==RUN
done  out  1  state==DONE
timeout  out  1  run ended by cycle budget
cycles  out  32  RUN cycles elapsed in current/last run

Behaviour:
- States: IDLE, RUN, DONE. Reset -> IDLE.
- Reset values: inst=NOP, proc_nrst=0, busy=0, done=0, timeout=0, cycles=0, log empty (log_valid=0), log_ovf=0. Program table is not cleared by reset; contents are retained.
- IDLE:
  - ld_en writes prog[ld_addr]=ld_data at the clock edge.
  - start -> RUN next cycle. On that edge cycles, timeout, log and log_ovf are cleared.
  - ld_en and start asserted together: the write completes, then RUN is entered.
- RUN:
  - proc_nrst=1.
  - Each cycle: inst <= prog[(pc-BASE_PC)>>2] when pc[1:0]==0 and BASE_PC <= pc < BASE_PC+4*DEPTH; otherwise inst <= NOP. Latency is 1 cycle from pc to inst.
  - cycles increments by 1 every RUN cycle.
  - pc==HALT_PC -> DONE, timeout=0.
  - Otherwise, when cycles==MAX_CYCLES-1 (this cycle is the last in budget) -> DONE with timeout=1, and cycles ends at MAX_CYCLES.
  - If both conditions hold in the same cycle, halt wins and timeout=0.
  - ld_en and start are ignored.
- DONE:
  - proc_nrst=0, inst=NOP, done=1. cycles, timeout and log are held.
  - start -> RUN with the same clears as from IDLE.
  - ld_en is ignored.
- Log FIFO (first-word-fall-through):
  - Push {addr,wdata,wmask} when wr_en && state==RUN.
  - Push while full: entry dropped, log_ovf set (sticky until start or rst).
  - Push and pop in the same cycle while full: both take effect, no overflow.
  - Pop while empty: ignored.
  - Pops are accepted in every state.
  - log_addr/log_data/log_mask hold the head entry whenever log_valid=1; don't-care otherwise.
- Reset mid-RUN: next cycle is IDLE, proc_nrst=0, log empty, program retained.
- cycles saturates at 32'hFFFF_FFFF (unreachable with legal MAX_CYCLES).

Test Plan:
1. rst held 2 cycles -> inst=0x00000013, proc_nrst=0, busy=0, done=0, log_valid=0, cycles=0.
2. Load prog[0]=0x00100093, prog[1]=0x00208093, start.
   - pc=0x0 -> inst=0x00100093 one cycle later.
   - pc=0x4 -> 0x00208093.
   - pc=0x2 -> NOP.
   - pc=0x80 -> NOP.
   - proc_nrst=1 throughout.
3. In RUN, pc=0x40 on 5th RUN cycle -> done=1 next cycle, timeout=0, cycles=5, proc_nrst=0, inst=NOP. ld_en in DONE leaves prog unchanged.
4. Start with pc held at 0x0 -> after 256 RUN cycles done=1, timeout=1, cycles=256. Repeat with pc=0x40 presented exactly on cycle 256 -> timeout=0.
5. Five wr_en pulses (addr 0x100..0x110, wdata 1..5, wmask 0xFF) with LOG_DEPTH=4:
   - Four entries are logged and log_ovf=1.
   - Pops return 0x100..0x10C in order, then log_valid=0.
   - Separate run: push and pop together while full -> no overflow, count stays 4.
6. rst mid-RUN with 2 log entries -> IDLE, log_valid=0, log_ovf=0. Restart with pc=0x0 -> inst=0x00100093 (program retained).
